imm_decode_stage: RTL and testbench

Registered immediate-decode stage for the RV32I front end. Accepts fetched instructions over a valid/ready handshake, classifies the format from the opcode, assembles the sign-extended 32-bit immediate and presents it one cycle later to the register-read/execute stage. A two-entry skid buffer gives full throughput under downstream backpressure. A flush input supports branch redirects.

---
 rtl/imm_decode_stage_pkg.sv | 41 ++++
 rtl/imm_decode_stage_assemble.sv | 45 ++++
 rtl/imm_decode_stage.sv | 102 ++++++++++
 tb/tb_imm_decode_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_stage_pkg.sv
// imm_pkg: shared types and constants for the RV32I immediate-decode stage
package imm_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        fmt_e              fmt;
        logic              illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_decode_stage_assemble.sv
// imm_assemble: combinational RV32I format classification and immediate assembly
module imm_assemble
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output fmt_e        fmt,
    output logic        illegal
);

    logic [6:0] opcode;
    logic       sign;

    assign opcode = instr[6:0];
    assign sign   = instr[31];

    // classify the opcode; anything outside the base set is flagged illegal
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC:                                  fmt = FMT_U;
            OP_JAL:                                            fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OP_IMM, OP_MISC_MEM, OP_SYSTEM: fmt = FMT_I;
            OP_BRANCH:                                         fmt = FMT_B;
            OP_STORE:                                          fmt = FMT_S;
            OP_OP:                                             fmt = FMT_R;
            default:                                           illegal = 1'b1;
        endcase
    end

    // gather the scattered immediate bits for the selected format
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{sign}}, instr[31:20]};
            FMT_S:   imm = {{20{sign}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{sign}}, sign, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{sign}}, sign, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decode with a two-entry skid buffer
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    state_e      state, state_nx;
    bundle_t     main_q, skid_q, dec;
    logic [31:0] dec_imm;
    fmt_e        dec_fmt;
    logic        dec_illegal;
    logic        accept, drain;
    logic        load_main, load_skid, pop_skid;

    imm_assemble u_assemble (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec = '{instr: in_instr, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    // ready depends only on registered state, so out_ready never reaches in_ready
    assign in_ready  = !rst && state != ST_TWO;
    assign out_valid = state != ST_EMPTY;
    assign accept    = in_valid && in_ready && !flush;
    assign drain     = out_valid && out_ready;

    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

    // occupancy transitions and which register captures what
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nx  = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    state_nx  = ST_TWO;
                    load_skid = 1'b1;
                end else if (accept) begin
                    load_main = 1'b1;
                end else if (drain) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain && !flush) begin
                    state_nx = ST_ONE;
                    pop_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    // state and bundle registers; reset clears everything, flush only empties
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= flush ? ST_EMPTY : state_nx;
            if (load_main)
                main_q <= dec;
            else if (pop_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: randomized self-checking bench with a queue reference model
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
    logic [2:0]  out_fmt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] fmt;
        logic [31:0] ill;
    } exp_t;

    exp_t q[$];
    bit   zeroed;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int   s, v;
        s = int'($signed(i)) >>> 31;
        e.instr = i;
        e.pc    = pc;
        e.ill   = 0;
        case (i[6:0])
            7'h37, 7'h17:                      e.fmt = 4;
            7'h6F:                             e.fmt = 5;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: e.fmt = 1;
            7'h63:                             e.fmt = 3;
            7'h23:                             e.fmt = 2;
            7'h33:                             e.fmt = 0;
            default: begin e.fmt = 0; e.ill = 1; end
        endcase
        case (e.fmt)
            1:       v = int'($signed(i)) >>> 20;
            2:       v = (int'($signed(i)) >>> 25) * 32 + int'(i[11:7]);
            3:       v = s * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            4:       v = int'(i & 32'hFFFFF000);
            5:       v = s * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        e.imm = 32'(v);
        return e;
    endfunction

    // one cycle: drive, compare against model mid-cycle, then advance model at the edge
    task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy);
        bit acc, drn;
        rst = r; flush = f; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        check("in_ready", 32'(in_ready), 32'(!r && q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_instr", out_instr, q[0].instr);
            check("out_pc", out_pc, q[0].pc);
            check("out_imm", out_imm, q[0].imm);
            check("out_fmt", 32'(out_fmt), q[0].fmt);
            check("out_illegal", 32'(out_illegal), q[0].ill);
        end else if (zeroed) begin
            check("rst_fields", out_instr | out_pc | out_imm | 32'(out_fmt) | 32'(out_illegal), 0);
        end
        acc = v && !r && !f && q.size() < 2;
        drn = ordy && q.size() > 0;
        @(posedge clk);
        if (r || f) begin
            q.delete();
            if (r) zeroed = 1;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(ins, pc));
                zeroed = 0;
                n_acc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 1);
    endtask

    logic [31:0] dir_ins [7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F,
                                 32'h12345037, 32'h00000000, 32'h00B50533};
    logic [31:0] dir_imm [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                 32'h12345000, 32'h00000000, 32'h00000000};
    logic [31:0] dir_fmt [7] = '{1, 2, 3, 5, 4, 0, 0};
    logic [31:0] dir_ill [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h0F, 7'h73};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        int          cyc;
        rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_imm", out_imm, 0);
        zeroed = 1;

        for (int k = 0; k < 7; k++) begin
            step(0, 0, 1, dir_ins[k], 32'h1000 + 32'(k * 4), 1);
            check("dir_valid", 32'(out_valid), 1);
            check("dir_instr", out_instr, dir_ins[k]);
            check("dir_imm", out_imm, dir_imm[k]);
            check("dir_fmt", 32'(out_fmt), dir_fmt[k]);
            check("dir_ill", 32'(out_illegal), dir_ill[k]);
        end
        idle(2);

        step(0, 0, 1, 32'h00100093, 32'h2000, 0);
        step(0, 0, 1, 32'h00200113, 32'h2004, 0);
        check("bp_in_ready", 32'(in_ready), 0);
        step(0, 0, 1, 32'h00300193, 32'h2008, 0);
        check("bp_hold", out_instr, 32'h00100093);
        step(0, 0, 1, 32'h00300193, 32'h2008, 1);
        check("bp_second", out_instr, 32'h00200113);
        step(0, 0, 1, 32'h00300193, 32'h2008, 1);
        check("bp_third", out_instr, 32'h00300193);
        idle(2);

        step(0, 0, 1, 32'h00400213, 32'h3000, 0);
        step(0, 0, 1, 32'h00500293, 32'h3004, 0);
        step(0, 1, 1, 32'h00600313, 32'h3008, 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        idle(3);

        step(0, 0, 1, 32'h00700393, 32'h4000, 0);
        step(0, 0, 1, 32'h00800413, 32'h4004, 1);
        step(1, 0, 1, 32'h00900493, 32'h4008, 1);
        check("rst2_valid", 32'(out_valid), 0);
        check("rst2_fields", out_instr | out_pc | out_imm | 32'(out_fmt) | 32'(out_illegal), 0);

        n_acc = 0;
        cyc = 0;
        while (n_acc < 100 && cyc < 2000) begin
            r  = $urandom();
            op = ($urandom_range(0, 5) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 10)];
            step(0, 0, 1, {r[31:7], op}, $urandom(), 1'($urandom_range(0, 1)));
            cyc++;
        end
        check("rand_accepts", 32'(n_acc), 100);
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            idle(1);
            cyc++;
        end
        check("drain_empty", 32'(q.size()), 0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
